// File: rtl/pio_in_edge.sv
// pio_in_edge: Avalon-MM slave input PIO with per-bit edge capture and a level interrupt.
// The external in_port bus passes through a two-flop synchronizer. A third flop (prev)
// holds the previous synchronized value so that edges can be detected.
// Selected edges are latched in a sticky edge-capture register. irq is asserted while
// any captured bit is also enabled in the mask register.
// Register map (word offsets): 0 DATA, 1 MASK, 2 EDGECAP, 3 reserved (reads 0).
// Optional macro PIO_IN_BITCLEAR_EN: when defined, a write to EDGECAP clears only the
// bits written as 1. When undefined, any write to EDGECAP clears every captured bit.
module pio_in_edge #(
    parameter int          WIDTH      = 32,
    parameter int          EDGE_TYPE  = 0,
    parameter logic [31:0] RESET_MASK = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] clr_bits;
    logic             wr_strobe;
    logic             wr_mask;
    logic             wr_edgecap;

    assign wr_strobe  = chipselect & ~write_n;
    assign wr_mask    = wr_strobe && (address == 2'd1);
    assign wr_edgecap = wr_strobe && (address == 2'd2);

    // Synchronize the asynchronous inputs and keep one extra stage for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Choose which transitions count as an edge. The selection is fixed at elaboration.
    always_comb begin
        case (EDGE_TYPE)
            1:       edge_det = ~sync2 & prev;
            2:       edge_det = sync2 ^ prev;
            default: edge_det = sync2 & ~prev;
        endcase
    end

    // Work out which captured bits a write to EDGECAP clears.
    always_comb begin
        clr_bits = '0;
        if (wr_edgecap) begin
`ifdef PIO_IN_BITCLEAR_EN
            clr_bits = writedata[WIDTH-1:0];
`else
            clr_bits = '1;
`endif
        end
    end

    // Update the sticky capture bits and the mask. A new edge wins over a clear in the
    // same cycle, so an event that arrives while software is clearing is not lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= '0;
            irq_mask <= RESET_MASK[WIDTH-1:0];
        end else begin
            edge_cap <= (edge_cap & ~clr_bits) | edge_det;
            if (wr_mask) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    // Drive the zero-wait read mux. Bits above WIDTH and unselected reads return 0.
    always_comb begin
        readdata = '0;
        if (chipselect) begin
            case (address)
                2'd0:    readdata[WIDTH-1:0] = sync2;
                2'd1:    readdata[WIDTH-1:0] = irq_mask;
                2'd2:    readdata[WIDTH-1:0] = edge_cap;
                default: readdata = '0;
            endcase
        end
    end

    assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_pio_in_edge.sv
// Testbench for pio_in_edge. Three instances with different WIDTH, EDGE_TYPE and
// RESET_MASK values share one stimulus stream. The reference model keeps a short
// history of sampled inputs, plus the capture and mask words, for each instance.
module tb_pio_in_edge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] in_port;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pio_in_edge #(.WIDTH(32), .EDGE_TYPE(0), .RESET_MASK(32'h0)) d0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .in_port(in_port), .irq(irq0));

    pio_in_edge #(.WIDTH(8), .EDGE_TYPE(2), .RESET_MASK(32'h0000_015A)) d1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd1),
        .in_port(in_port[7:0]), .irq(irq1));

    pio_in_edge #(.WIDTH(16), .EDGE_TYPE(1), .RESET_MASK(32'h0000_FFFF)) d2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd2),
        .in_port(in_port[15:0]), .irq(irq2));

    // Reference model configuration and state
    int          etype [3] = '{0, 2, 1};
    logic [31:0] wmask [3] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'h0000_FFFF};
    logic [31:0] rmask [3] = '{32'h0, 32'h0000_015A, 32'h0000_FFFF};
    logic [31:0] m_cap [3];
    logic [31:0] m_mask[3];
    // Input samples taken at the last three clock edges: [2] newest, [1] the value the
    // DATA register shows, [0] the value one cycle older than that.
    logic [31:0] q_samp[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q_samp = {};
        repeat (3) q_samp.push_back(32'h0);
        for (int i = 0; i < 3; i++) begin
            m_cap[i]  = 32'h0;
            m_mask[i] = rmask[i] & wmask[i];
        end
    endtask

    task automatic model_clock(input logic [31:0] inp, input logic cs_i, input logic wn_i,
                               input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] now_v, old_v, e, clr;
        logic        wr;
        now_v = q_samp[1];
        old_v = q_samp[0];
        wr    = cs_i & ~wn_i;
        for (int i = 0; i < 3; i++) begin
            case (etype[i])
                0:       e = now_v & ~old_v;
                1:       e = ~now_v & old_v;
                default: e = now_v ^ old_v;
            endcase
            e   = e & wmask[i];
            clr = 32'h0;
            if (wr && a == 2'd2) begin
`ifdef PIO_IN_BITCLEAR_EN
                clr = wd;
`else
                clr = 32'hFFFF_FFFF;
`endif
            end
            m_cap[i] = ((m_cap[i] & ~clr) | e) & wmask[i];
            if (wr && a == 2'd1) m_mask[i] = wd & wmask[i];
        end
        q_samp.push_back(inp);
        void'(q_samp.pop_front());
    endtask

    function automatic logic [31:0] model_read(input int i);
        if (!chipselect) return 32'h0;
        case (address)
            2'd0:    return q_samp[1] & wmask[i];
            2'd1:    return m_mask[i];
            2'd2:    return m_cap[i];
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] get_rd(input int i);
        case (i)
            0:       return rd0;
            1:       return rd1;
            default: return rd2;
        endcase
    endfunction

    function automatic logic get_irq(input int i);
        case (i)
            0:       return irq0;
            1:       return irq1;
            default: return irq2;
        endcase
    endfunction

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("rd%0d_a%0d", i, address), get_rd(i), model_read(i));
            check_val($sformatf("irq%0d", i), {31'b0, get_irq(i)},
                      {31'b0, |(m_cap[i] & m_mask[i])});
        end
    endtask

    // One bus cycle: drive the inputs, take the clock edge, then compare just after it.
    task automatic step(input logic [31:0] inp, input logic cs_i, input logic wn_i,
                        input logic [1:0] a, input logic [31:0] wd);
        in_port    = inp;
        chipselect = cs_i;
        write_n    = wn_i;
        address    = a;
        writedata  = wd;
        @(posedge clk);
        if (reset_n) model_clock(inp, cs_i, wn_i, a, wd);
        #1;
        check_all();
    endtask

    task automatic rd_step(input logic [31:0] inp, input logic [1:0] a);
        step(inp, 1'b1, 1'b1, a, 32'h0);
    endtask

    task automatic wr_step(input logic [31:0] inp, input logic [1:0] a, input logic [31:0] wd);
        step(inp, 1'b1, 1'b0, a, wd);
    endtask

    // Let the inputs settle at the given value, then clear every captured bit.
    task automatic settle_clear(input logic [31:0] inp);
        repeat (4) rd_step(inp, 2'd0);
        wr_step(inp, 2'd2, 32'hFFFF_FFFF);
        rd_step(inp, 2'd2);
    endtask

    task automatic pulse_reset(input int cycles);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (cycles) rd_step($urandom, 2'($urandom_range(0, 3)));
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] cur;
        reset_n    = 1'b0;
        in_port    = 32'hFFFF_FFFF;
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'h0;
        model_reset();

        // Reset state while the inputs are held high
        repeat (3) @(posedge clk);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            check_all();
        end
        address = 2'd1;
        #1;
        check_val("rst_mask_d1", rd1, 32'h0000_005A);
        check_val("rst_mask_d2", rd2, 32'h0000_FFFF);
        check_val("rst_irq_d1", {31'b0, irq1}, 32'h0);
        #1;
        reset_n = 1'b1;

        // An input that is already high at reset release is captured as a rising edge
        rd_step(32'hFFFF_FFFF, 2'd2);
        rd_step(32'hFFFF_FFFF, 2'd2);
        check_val("rel_cap_early", rd0, 32'h0);
        rd_step(32'hFFFF_FFFF, 2'd2);
        check_val("rel_cap", rd0, 32'hFFFF_FFFF);
        settle_clear(32'h0);
        settle_clear(32'h0);

        // DATA read latency
        rd_step(32'h0000_00A5, 2'd0);
        check_val("data_k", rd0, 32'h0);
        rd_step(32'h0000_00A5, 2'd0);
        check_val("data_k1", rd0, 32'h0000_00A5);
        settle_clear(32'h0);

        // Rising capture with mask, then mask removal
        wr_step(32'h0, 2'd1, 32'h1);
        rd_step(32'h1, 2'd2);
        rd_step(32'h1, 2'd2);
        rd_step(32'h1, 2'd2);
        check_val("cap_rise", rd0, 32'h1);
        check_val("irq_rise", {31'b0, irq0}, 32'h1);
        wr_step(32'h0, 2'd1, 32'h0);
        check_val("irq_unmask", {31'b0, irq0}, 32'h0);

        // Clearing captured bits
        settle_clear(32'h0);
        repeat (4) rd_step(32'h3, 2'd2);
        check_val("cap_two", rd0, 32'h3);
        wr_step(32'h3, 2'd2, 32'h1);
`ifdef PIO_IN_BITCLEAR_EN
        check_val("clr_partial", rd0, 32'h2);
`else
        check_val("clr_all", rd0, 32'h0);
`endif

        // A new edge in the same cycle as a clear wins
        settle_clear(32'h0);
        wr_step(32'h0, 2'd1, 32'h1);
        rd_step(32'h1, 2'd2);
        rd_step(32'h0, 2'd2);
        rd_step(32'h1, 2'd2);
        check_val("sim_pre", rd0, 32'h1);
        rd_step(32'h1, 2'd2);
        wr_step(32'h1, 2'd2, 32'h1);
        check_val("sim_cap", rd0, 32'h1);
        check_val("sim_irq", {31'b0, irq0}, 32'h1);

        // Narrow instance with any-edge capture: a falling edge on bit 3
        settle_clear(32'h8);
        rd_step(32'h0, 2'd2);
        rd_step(32'h0, 2'd2);
        rd_step(32'h0, 2'd2);
        check_val("any_fall_d1", rd1, 32'h0000_0008);
        wr_step(32'h0, 2'd1, 32'hFFFF_FFFF);
        check_val("mask_trunc_d1", rd1, 32'h0000_00FF);
        rd_step(32'h0, 2'd3);
        check_val("reserved_d1", rd1, 32'h0);

        // Randomized traffic, including occasional asynchronous resets mid-operation
        cur = 32'h0;
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 5))
                0:       cur = $urandom;
                1:       cur = cur ^ (32'h1 << $urandom_range(0, 31));
                2:       cur = cur ^ (32'h1 << $urandom_range(0, 7));
                default: ;
            endcase
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset($urandom_range(1, 3));
            end else begin
                step(cur, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                     2'($urandom_range(0, 3)),
                     ($urandom_range(0, 1) == 1) ? $urandom : 32'hFFFF_FFFF);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
